// File: rtl/tick_sequencer.sv
// tick_sequencer: run/pause/single-step timebase with a programmable prescaler.
// Ports: clk, rst (async, active-high); start/stop/step commands;
//   cfg_valid/cfg_div/cfg_ready divisor handshake; tick, sq_out, busy, state.
// Option: define TICKSEQ_SYNC_EN to synchronize and edge-detect the commands.
module tick_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50_000_000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             sq_out,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_STEP  = 2'b11
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_div;
  logic             pend;
  logic             go_start;
  logic             go_stop;
  logic             go_step;
  logic             wrap;
  logic             active;

`ifdef TICKSEQ_SYNC_EN
  // bit0/bit1 form the 2-FF synchronizer, bit2 is the edge-detect delay
  logic [2:0] s_start;
  logic [2:0] s_stop;
  logic [2:0] s_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_start <= '0;
      s_stop  <= '0;
      s_step  <= '0;
    end else begin
      s_start <= {s_start[1:0], start};
      s_stop  <= {s_stop[1:0], stop};
      s_step  <= {s_step[1:0], step};
    end
  end

  assign go_start = s_start[1] & ~s_start[2];
  assign go_stop  = s_stop[1] & ~s_stop[2];
  assign go_step  = s_step[1] & ~s_step[2];
`else
  assign go_start = start;
  assign go_stop  = stop;
  assign go_step  = step;
`endif

  // div_q is never 0, so div_q-1 cannot underflow
  assign wrap      = (cnt == div_q - WIDTH'(1));
  assign active    = st[0];
  assign busy      = st[0];
  assign state     = st;
  assign cfg_ready = ~pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      cnt      <= '0;
      div_q    <= DEFAULT_DIV;
      pend_div <= DEFAULT_DIV;
      pend     <= 1'b0;
      tick     <= 1'b0;
      sq_out   <= 1'b0;
    end else begin
      tick <= 1'b0;

      if (cfg_valid && !pend) begin
        pend_div <= (cfg_div == '0) ? WIDTH'(1) : cfg_div;
        pend     <= 1'b1;
      end

      // while not counting there is no period to protect
      if (pend && !active) begin
        div_q <= pend_div;
        pend  <= 1'b0;
      end

      unique case (st)
        S_IDLE: begin
          cnt <= '0;
          if (go_start) st <= S_RUN;
          else if (go_step) st <= S_STEP;
        end
        S_RUN: begin
          if (go_stop) begin
            st <= S_PAUSE;
          end else if (wrap) begin
            cnt    <= '0;
            tick   <= 1'b1;
            sq_out <= ~sq_out;
            if (pend) begin
              div_q <= pend_div;
              pend  <= 1'b0;
            end
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        S_PAUSE: begin
          if (go_stop) begin
            st     <= S_IDLE;
            cnt    <= '0;
            sq_out <= 1'b0;
          end else begin
            if (pend && cnt >= pend_div) cnt <= '0;
            if (go_start) st <= S_RUN;
            else if (go_step) st <= S_STEP;
          end
        end
        S_STEP: begin
          if (go_stop) begin
            st     <= S_IDLE;
            cnt    <= '0;
            sq_out <= 1'b0;
          end else begin
            if (wrap) begin
              cnt    <= '0;
              tick   <= 1'b1;
              sq_out <= ~sq_out;
              if (pend) begin
                div_q <= pend_div;
                pend  <= 1'b0;
              end
            end else begin
              cnt <= cnt + WIDTH'(1);
            end
            if (go_start) st <= S_RUN;
            else if (wrap) st <= S_PAUSE;
          end
        end
      endcase
    end
  end

endmodule
